// File: rtl/gamma_peak_detect.sv
// Peak search on the |gamma|^2 stream from the CP correlator: one result per WIN_LEN-sample window,
// reporting the in-window index, magnitude and complex gamma of the earliest maximum.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start
// S_WARMUP| discarding WARMUP valid samples while the upstream window fills
// S_SEARCH| back-to-back windows; one out_valid strobe per completed window
module gamma_peak_detect #(
    parameter int GAMMA_W = 14,
    parameter int WIN_LEN = 80,
    parameter int WARMUP  = 16,
    parameter int IDX_W   = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      in_valid,
    input  logic signed [GAMMA_W-1:0] gamma_in_real,
    input  logic signed [GAMMA_W-1:0] gamma_in_imag,
    output logic                      busy,
    output logic                      out_valid,
    output logic [IDX_W-1:0]          peak_idx,
    output logic [2*GAMMA_W-1:0]      peak_mag,
    output logic [GAMMA_W-1:0]        peak_real,
    output logic [GAMMA_W-1:0]        peak_imag
);

    localparam int MAG_W  = 2 * GAMMA_W;
    localparam int SQ_W   = MAG_W - 1;
    localparam int WCNT_W = (WARMUP > 2) ? $clog2(WARMUP) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WIN_LEN - 1);
    localparam logic [WCNT_W-1:0] WARM_LAST = WCNT_W'((WARMUP > 0) ? WARMUP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WARMUP = 2'd1,
        S_SEARCH = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   warm_cnt_q, warm_cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                busy_q, busy_d;

    logic                s1_vld_q, s1_vld_d;
    logic                s1_first_q, s1_first_d;
    logic                s1_last_q, s1_last_d;
    logic [IDX_W-1:0]    s1_idx_q, s1_idx_d;
    logic [SQ_W-1:0]     s1_re2_q, s1_re2_d;
    logic [SQ_W-1:0]     s1_im2_q, s1_im2_d;
    logic [GAMMA_W-1:0]  s1_real_q, s1_real_d;
    logic [GAMMA_W-1:0]  s1_imag_q, s1_imag_d;

    logic [MAG_W-1:0]    max_q, max_d;
    logic [IDX_W-1:0]    max_idx_q, max_idx_d;
    logic [GAMMA_W-1:0]  max_real_q, max_real_d;
    logic [GAMMA_W-1:0]  max_imag_q, max_imag_d;

    logic                out_valid_q, out_valid_d;
    logic [IDX_W-1:0]    peak_idx_q, peak_idx_d;
    logic [MAG_W-1:0]    peak_mag_q, peak_mag_d;
    logic [GAMMA_W-1:0]  peak_real_q, peak_real_d;
    logic [GAMMA_W-1:0]  peak_imag_q, peak_imag_d;

    // Squaring the magnitude keeps the product unsigned and one bit narrower;
    // |-2^(W-1)| = 2^(W-1) still fits in W unsigned bits.
    logic [GAMMA_W-1:0]  re_u, im_u, abs_re, abs_im;
    logic [SQ_W-1:0]     sq_re, sq_im;
    logic [MAG_W-1:0]    mag;
    logic                take;

    always_comb begin
        re_u   = gamma_in_real;
        im_u   = gamma_in_imag;
        abs_re = re_u[GAMMA_W-1] ? (~re_u + GAMMA_W'(1)) : re_u;
        abs_im = im_u[GAMMA_W-1] ? (~im_u + GAMMA_W'(1)) : im_u;
        sq_re  = {{(SQ_W-GAMMA_W){1'b0}}, abs_re} * {{(SQ_W-GAMMA_W){1'b0}}, abs_re};
        sq_im  = {{(SQ_W-GAMMA_W){1'b0}}, abs_im} * {{(SQ_W-GAMMA_W){1'b0}}, abs_im};
        mag    = {1'b0, s1_re2_q} + {1'b0, s1_im2_q};
        take   = s1_first_q || (mag > max_q);
    end

    always_comb begin
        state_d     = state_q;
        warm_cnt_d  = warm_cnt_q;
        idx_d       = idx_q;
        s1_vld_d    = 1'b0;
        s1_first_d  = s1_first_q;
        s1_last_d   = s1_last_q;
        s1_idx_d    = s1_idx_q;
        s1_re2_d    = s1_re2_q;
        s1_im2_d    = s1_im2_q;
        s1_real_d   = s1_real_q;
        s1_imag_d   = s1_imag_q;
        max_d       = max_q;
        max_idx_d   = max_idx_q;
        max_real_d  = max_real_q;
        max_imag_d  = max_imag_q;
        out_valid_d = 1'b0;
        peak_idx_d  = peak_idx_q;
        peak_mag_d  = peak_mag_q;
        peak_real_d = peak_real_q;
        peak_imag_d = peak_imag_q;

        if (start) begin
            // Restart drops the sample in stage 1 and any partial window.
            state_d    = (WARMUP == 0) ? S_SEARCH : S_WARMUP;
            warm_cnt_d = '0;
            idx_d      = '0;
            max_d      = '0;
        end else begin
            unique case (state_q)
                S_IDLE: ;
                S_WARMUP: begin
                    if (in_valid) begin
                        if (warm_cnt_q == WARM_LAST) begin
                            state_d = S_SEARCH;
                            idx_d   = '0;
                        end else begin
                            warm_cnt_d = warm_cnt_q + WCNT_W'(1);
                        end
                    end
                end
                S_SEARCH: begin
                    if (in_valid) begin
                        s1_vld_d   = 1'b1;
                        s1_first_d = (idx_q == '0);
                        s1_last_d  = (idx_q == IDX_LAST);
                        s1_idx_d   = idx_q;
                        s1_re2_d   = sq_re;
                        s1_im2_d   = sq_im;
                        s1_real_d  = gamma_in_real;
                        s1_imag_d  = gamma_in_imag;
                        idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase

            if (s1_vld_q) begin
                if (take) begin
                    max_d      = mag;
                    max_idx_d  = s1_idx_q;
                    max_real_d = s1_real_q;
                    max_imag_d = s1_imag_q;
                end
                if (s1_last_q) begin
                    out_valid_d = 1'b1;
                    peak_idx_d  = take ? s1_idx_q  : max_idx_q;
                    peak_mag_d  = take ? mag       : max_q;
                    peak_real_d = take ? s1_real_q : max_real_q;
                    peak_imag_d = take ? s1_imag_q : max_imag_q;
                end
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            warm_cnt_q  <= '0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            s1_vld_q    <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_idx_q    <= '0;
            s1_re2_q    <= '0;
            s1_im2_q    <= '0;
            s1_real_q   <= '0;
            s1_imag_q   <= '0;
            max_q       <= '0;
            max_idx_q   <= '0;
            max_real_q  <= '0;
            max_imag_q  <= '0;
            out_valid_q <= 1'b0;
            peak_idx_q  <= '0;
            peak_mag_q  <= '0;
            peak_real_q <= '0;
            peak_imag_q <= '0;
        end else begin
            state_q     <= state_d;
            warm_cnt_q  <= warm_cnt_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            s1_vld_q    <= s1_vld_d;
            s1_first_q  <= s1_first_d;
            s1_last_q   <= s1_last_d;
            s1_idx_q    <= s1_idx_d;
            s1_re2_q    <= s1_re2_d;
            s1_im2_q    <= s1_im2_d;
            s1_real_q   <= s1_real_d;
            s1_imag_q   <= s1_imag_d;
            max_q       <= max_d;
            max_idx_q   <= max_idx_d;
            max_real_q  <= max_real_d;
            max_imag_q  <= max_imag_d;
            out_valid_q <= out_valid_d;
            peak_idx_q  <= peak_idx_d;
            peak_mag_q  <= peak_mag_d;
            peak_real_q <= peak_real_d;
            peak_imag_q <= peak_imag_d;
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign peak_idx  = peak_idx_q;
    assign peak_mag  = peak_mag_q;
    assign peak_real = peak_real_q;
    assign peak_imag = peak_imag_q;

endmodule

// File: tb/tb_gamma_peak_detect.sv
// Directed bench for gamma_peak_detect: a negedge monitor records every strobe,
// and each scenario task compares the recorded strobes against hand-computed values.
module tb_gamma_peak_detect;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic               in_valid = 1'b0;
    logic signed [13:0] gr = '0;
    logic signed [13:0] gi = '0;
    logic               busy, out_valid;
    logic [6:0]         peak_idx;
    logic [27:0]        peak_mag;
    logic [13:0]        peak_real, peak_imag;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_cyc = 0;

    typedef struct {
        logic [6:0]  idx;
        logic [27:0] mag;
        logic [13:0] re;
        logic [13:0] im;
        int          cyc;
    } strobe_t;

    strobe_t sq[$];

    gamma_peak_detect #(.GAMMA_W(14), .WIN_LEN(80), .WARMUP(16), .IDX_W(7)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .gamma_in_real(gr), .gamma_in_imag(gi),
        .busy(busy), .out_valid(out_valid), .peak_idx(peak_idx),
        .peak_mag(peak_mag), .peak_real(peak_real), .peak_imag(peak_imag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid === 1'b1)
            sq.push_back('{idx: peak_idx, mag: peak_mag, re: peak_real, im: peak_imag, cyc: cyc});
    end

    function automatic strobe_t get_strobe(input int k);
        strobe_t s;
        s = '{idx: 'x, mag: 'x, re: 'x, im: 'x, cyc: -1};
        if (k < sq.size()) s = sq[k];
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int re, input int im, input int gap);
        repeat (gap) tick();
        in_valid = 1'b1;
        gr = 14'(re);
        gi = 14'(im);
        tick();
        in_valid = 1'b0;
        last_cyc = cyc;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic warmup(input int re, input int im);
        repeat (16) send(re, im, 0);
    endtask

    task automatic send_window(input int pk1, input int pk2, input int pr, input int pi, input int gapmax);
        for (int i = 0; i < 80; i++) begin
            int g;
            g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
            if (i == pk1 || i == pk2) send(pr, pi, g);
            else send(1, 0, g);
        end
    endtask

    task automatic test_reset();
        strobe_t s;
        rst = 1'b0;
        repeat (3) tick();
        n_checks++; if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid got %0b want 0", out_valid); n_fail++; end
        n_checks++; if (busy !== 1'b0) begin $display("FAIL reset_busy got %0b want 0", busy); n_fail++; end
        n_checks++; if (peak_idx !== 7'd0) begin $display("FAIL reset_peak_idx got %0d want 0", peak_idx); n_fail++; end
        n_checks++; if (peak_mag !== 28'd0) begin $display("FAIL reset_peak_mag got %0h want 0", peak_mag); n_fail++; end
        n_checks++; if (peak_real !== 14'd0) begin $display("FAIL reset_peak_real got %0h want 0", peak_real); n_fail++; end
        n_checks++; if (peak_imag !== 14'd0) begin $display("FAIL reset_peak_imag got %0h want 0", peak_imag); n_fail++; end
        rst = 1'b1;
        sq.delete();
        repeat (100) send(7, 3, 0);
        repeat (4) tick();
        n_checks++; if (sq.size() !== 0) begin s = get_strobe(0); $display("FAIL idle_no_strobe got %0d strobes (first idx %0d) want 0", sq.size(), s.idx); n_fail++; end
        n_checks++; if (busy !== 1'b0) begin $display("FAIL idle_busy got %0b want 0", busy); n_fail++; end
    endtask

    task automatic test_single_peak();
        strobe_t s;
        sq.delete();
        do_start();
        n_checks++; if (busy !== 1'b1) begin $display("FAIL start_busy got %0b want 1", busy); n_fail++; end
        warmup(5, 5);
        send_window(37, -1, 256, -128, 0);
        repeat (4) tick();
        s = get_strobe(0);
        n_checks++; if (sq.size() !== 1) begin $display("FAIL single_count got %0d want 1", sq.size()); n_fail++; end
        n_checks++; if (s.idx !== 7'd37) begin $display("FAIL single_idx got %0d want 37", s.idx); n_fail++; end
        n_checks++; if (s.mag !== 28'h14000) begin $display("FAIL single_mag got %0h want 14000", s.mag); n_fail++; end
        n_checks++; if (s.re !== 14'h0100) begin $display("FAIL single_real got %0h want 0100", s.re); n_fail++; end
        n_checks++; if (s.im !== 14'h3F80) begin $display("FAIL single_imag got %0h want 3f80", s.im); n_fail++; end
        n_checks++; if (s.cyc !== last_cyc + 1) begin $display("FAIL single_latency got cycle %0d want %0d", s.cyc, last_cyc + 1); n_fail++; end
        n_checks++; if (peak_idx !== 7'd37 || out_valid !== 1'b0) begin $display("FAIL single_hold got idx %0d ov %0b want 37 0", peak_idx, out_valid); n_fail++; end
    endtask

    task automatic test_tie_warmup();
        strobe_t s;
        sq.delete();
        do_start();
        warmup(4000, 4000);
        send_window(10, 60, 3, 4, 0);
        repeat (4) tick();
        s = get_strobe(0);
        n_checks++; if (sq.size() !== 1) begin $display("FAIL tie_count got %0d want 1", sq.size()); n_fail++; end
        n_checks++; if (s.idx !== 7'd10) begin $display("FAIL tie_idx got %0d want 10", s.idx); n_fail++; end
        n_checks++; if (s.mag !== 28'd25) begin $display("FAIL tie_mag got %0d want 25", s.mag); n_fail++; end
        n_checks++; if (s.re !== 14'd3 || s.im !== 14'd4) begin $display("FAIL tie_value got %0h,%0h want 3,4", s.re, s.im); n_fail++; end
    endtask

    task automatic test_back_to_back();
        strobe_t s0, s1;
        sq.delete();
        do_start();
        warmup(5, 5);
        send_window(79, -1, 2, 0, 2);
        send_window(0, -1, 3, 0, 2);
        repeat (4) tick();
        s0 = get_strobe(0);
        s1 = get_strobe(1);
        n_checks++; if (sq.size() !== 2) begin $display("FAIL b2b_count got %0d want 2", sq.size()); n_fail++; end
        n_checks++; if (s0.idx !== 7'd79 || s0.mag !== 28'd4) begin $display("FAIL b2b_win1 got idx %0d mag %0d want 79 4", s0.idx, s0.mag); n_fail++; end
        n_checks++; if (s0.re !== 14'd2 || s0.im !== 14'd0) begin $display("FAIL b2b_win1_value got %0h,%0h want 2,0", s0.re, s0.im); n_fail++; end
        n_checks++; if (s1.idx !== 7'd0 || s1.mag !== 28'd9) begin $display("FAIL b2b_win2 got idx %0d mag %0d want 0 9", s1.idx, s1.mag); n_fail++; end
        n_checks++; if (s1.cyc !== last_cyc + 1) begin $display("FAIL b2b_latency got cycle %0d want %0d", s1.cyc, last_cyc + 1); n_fail++; end
    endtask

    task automatic test_extreme();
        strobe_t s;
        sq.delete();
        do_start();
        warmup(5, 5);
        send_window(5, -1, -8192, -8192, 0);
        repeat (4) tick();
        s = get_strobe(0);
        n_checks++; if (sq.size() !== 1 || s.idx !== 7'd5) begin $display("FAIL extreme_idx got %0d strobes idx %0d want 1 5", sq.size(), s.idx); n_fail++; end
        n_checks++; if (s.mag !== 28'h8000000) begin $display("FAIL extreme_mag got %0h want 8000000", s.mag); n_fail++; end
        n_checks++; if (s.re !== 14'h2000 || s.im !== 14'h2000) begin $display("FAIL extreme_value got %0h,%0h want 2000,2000", s.re, s.im); n_fail++; end
    endtask

    task automatic test_restart();
        strobe_t s;
        sq.delete();
        do_start();
        warmup(5, 5);
        for (int i = 0; i < 50; i++) send(1, 0, 0);
        // Restart with a large sample in the same cycle; it must be ignored.
        start = 1'b1; in_valid = 1'b1; gr = 14'sd4000; gi = 14'sd4000;
        tick();
        start = 1'b0; in_valid = 1'b0;
        repeat (5) tick();
        n_checks++; if (sq.size() !== 0) begin $display("FAIL restart_no_strobe got %0d want 0", sq.size()); n_fail++; end
        n_checks++; if (busy !== 1'b1) begin $display("FAIL restart_busy got %0b want 1", busy); n_fail++; end
        warmup(6, 6);
        send_window(20, -1, 2, 0, 0);
        repeat (4) tick();
        s = get_strobe(0);
        n_checks++; if (sq.size() !== 1 || s.idx !== 7'd20) begin $display("FAIL restart_idx got %0d strobes idx %0d want 1 20", sq.size(), s.idx); n_fail++; end
        n_checks++; if (s.mag !== 28'd4) begin $display("FAIL restart_mag got %0d want 4", s.mag); n_fail++; end
        n_checks++; if (s.cyc !== last_cyc + 1) begin $display("FAIL restart_latency got cycle %0d want %0d", s.cyc, last_cyc + 1); n_fail++; end
    endtask

    task automatic test_mid_reset();
        sq.delete();
        do_start();
        warmup(5, 5);
        for (int i = 0; i < 79; i++) send(1, 0, 0);
        in_valid = 1'b1; gr = 14'sd2; gi = 14'sd0;
        rst = 1'b0;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin $display("FAIL midrst_ctrl got busy %0b ov %0b want 0 0", busy, out_valid); n_fail++; end
        n_checks++; if (peak_idx !== 7'd0 || peak_mag !== 28'd0) begin $display("FAIL midrst_peak got idx %0d mag %0h want 0 0", peak_idx, peak_mag); n_fail++; end
        n_checks++; if (peak_real !== 14'd0 || peak_imag !== 14'd0) begin $display("FAIL midrst_value got %0h,%0h want 0,0", peak_real, peak_imag); n_fail++; end
        repeat (90) send(1, 0, 0);
        repeat (4) tick();
        n_checks++; if (sq.size() !== 0) begin $display("FAIL midrst_no_strobe got %0d want 0", sq.size()); n_fail++; end
        n_checks++; if (busy !== 1'b0) begin $display("FAIL midrst_idle got busy %0b want 0", busy); n_fail++; end
    endtask

    initial begin
        test_reset();
        test_single_peak();
        test_tie_warmup();
        test_back_to_back();
        test_extreme();
        test_restart();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
